uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive path behind the top-level `uart_rx` pin; drives `uart_rts` back to the pad.
- Synchronises the asynchronous serial line and deframes 8N1-style frames, LSB first, with mid-bit sampling.
- Buffers received bytes in a first-word-fall-through FIFO with a valid/ready interface toward the peripheral bus.
- Raises per-frame error/overrun pulses and drives hardware flow control.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
FIFO_DEPTH, 8, FIFO entries; power of two, >= 4
DIV_WIDTH, 16, width of the bit-period divisor

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_en_i  input  1  receiver enable
cfg_div_i  input  DIV_WIDTH  bit period minus one, in clk cycles; legal values >= 3
uart_rx  input  1  serial line, asynchronous, idle high
uart_rts  output  1  request-to-send, active low (0 = may send)
rx_data_o  output  DATA_BITS  FIFO head byte
rx_valid_o  output  1  FIFO non-empty
rx_ready_i  input  1  consumer accepts head this cycle
rx_count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_err_o  output  1  one-cycle pulse: stop bit sampled 0
overrun_o  output  1  one-cycle pulse: byte dropped, FIFO full

Behaviour:
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values:
  - FSM = IDLE; synchroniser flops and previous-sample flop = 1.
  - `rx_valid_o` = 0, `rx_data_o` = 0, `rx_count_o` = 0.
  - `frame_err_o` = 0, `overrun_o` = 0, `uart_rts` = 1.
- Input synchroniser: 2 flops. All FSM decisions use the synchronised line `rxs`. Edge detection compares `rxs` with its 1-cycle-delayed copy.
- Bit counter:
  - Down-counter, DIV_WIDTH bits. A sample event occurs when it reaches 0.
  - It reloads `cfg_div_i` on each sample event, except where noted below.
  - `cfg_div_i` is read only at load time, so a change mid-frame takes effect at the next load.
- FSM states and transitions:
  - IDLE: on a falling edge of `rxs` with `cfg_en_i`=1, load counter with `cfg_div_i>>1` and go to START.
  - START: on sample event:
    - `rxs`=1: false start; go to IDLE, nothing recorded.
    - otherwise: load `cfg_div_i`, clear bit index, go to DATA.
  - DATA: on each sample event, shift `rxs` into the shift register at the MSB, shifting right (LSB-first frame). After the DATA_BITS-th sample, go to STOP.
  - STOP: on sample event:
    - `rxs`=1: push byte, go to IDLE.
    - `rxs`=0: pulse `frame_err_o` for 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. A break condition therefore yields exactly one `frame_err_o`.
- `cfg_en_i`=0: FSM forced to IDLE the next cycle and any partial frame is discarded. FIFO contents, outputs and pop are unaffected.
- Latency: the pushed byte is visible on `rx_data_o` with `rx_valid_o` (if the FIFO was empty) in the cycle after the stop-bit sample cycle.
- FIFO:
  - `rx_valid_o` = (count != 0); `rx_data_o` = head entry, held stable while valid and not popped.
  - Pop occurs when `rx_valid_o & rx_ready_i`. Pointers wrap modulo FIFO_DEPTH.
  - Push while full with no pop: byte dropped, `overrun_o` pulses 1 cycle, contents unchanged.
  - Push while full with a pop in the same cycle: push accepted, no overrun, count unchanged.
  - Push and pop in the same cycle when non-empty: count unchanged.
  - Push into empty FIFO with `rx_ready_i`=1: byte must first appear (valid) for at least one cycle; no bypass.
- `uart_rts` is registered. Next value = 1 if `cfg_en_i`=0 or count >= FIFO_DEPTH-2, else 0.
- Simultaneous `frame_err_o` and `overrun_o` cannot occur (mutually exclusive STOP outcomes).

Test Plan:
- div=15, send 0xA5, valid stop, ready=0 → `rx_valid_o`=1, `rx_data_o`=0xA5 one cycle after stop sample; count=1; no error pulses.
- div=15, 4-cycle low glitch on idle line → START rejects it; no push, no error; then 0x3C received correctly.
- div=15, send 0x3C with stop bit 0, line held low 40 cycles → exactly one `frame_err_o` pulse, count stays 0; then 0x5A received correctly.
- DEPTH=8, ready=0, send 0x00..0x08 → `uart_rts`=1 from the cycle after count reaches 6; 9th byte gives one `overrun_o` pulse; draining yields 0x00..0x07 in order.
- FIFO full, `rx_ready_i`=1 in the push cycle of 0x77 → no overrun, count stays 8, 0x77 becomes the last entry.
- Assert `rst_n` during data bit 3 → outputs reach reset values asynchronously; after release and a 1-cycle `uart_rts` high, 0x81 sent and received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1-style, LSB first) with FWFT receive FIFO and RTS flow control
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cfg_en_i     receiver enable
//   cfg_div_i    bit period minus one, in clk cycles (>= 3)
//   uart_rx      asynchronous serial line, idle high
//   uart_rts     registered request-to-send, active low
//   rx_data_o    FIFO head byte (0 while empty)
//   rx_valid_o   FIFO non-empty
//   rx_ready_i   consumer accepts head this cycle
//   rx_count_o   FIFO occupancy
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: received byte dropped because FIFO full
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en_i,
  input  logic [DIV_WIDTH-1:0]          cfg_div_i,
  input  logic                          uart_rx,
  output logic                          uart_rts,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser and edge history (idle-high reset values so that
  // leaving reset never looks like a start edge)
  // ---------------------------------------------------------------------
  logic sync1, rxs, rxs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  wire fall_edge = rxs_d & ~rxs;

  // ---------------------------------------------------------------------
  // Deframing FSM
  // ---------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push;
  logic                 ferr_evt;

  wire sample = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_evt = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Half a bit period puts the following samples mid-bit.
        if (cfg_en_i && fall_edge) begin
          cnt_d   = cfg_div_i >> 1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (sample) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cfg_div_i;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (sample) begin
          // LSB arrives first, so after DATA_BITS right-shifts it sits at bit 0.
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cfg_div_i;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        if (sample) begin
          cnt_d = cfg_div_i;
          if (rxs) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_evt = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        // Holding here on a low line keeps a break to a single error pulse.
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Disable abandons whatever frame is in progress.
    if (!cfg_en_i) begin
      state_d  = S_IDLE;
      push     = 1'b0;
      ferr_evt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  wire full    = (count == CNT_W'(FIFO_DEPTH));
  wire pop     = rx_valid_o & rx_ready_i;
  // A pop in the same cycle frees the slot the push lands in.
  wire push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
      uart_rts    <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun_o   <= push & full & ~pop;
      frame_err_o <= ferr_evt;
      uart_rts    <= ~cfg_en_i | (count >= CNT_W'(FIFO_DEPTH - 2));
    end
  end

  assign rx_valid_o = (count != '0);
  assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : '0;
  assign rx_count_o = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic        uart_rx;
  logic        uart_rts;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [3:0]  rx_count_o;
  logic        frame_err_o;
  logic        overrun_o;

  uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en_i    (cfg_en_i),
    .cfg_div_i   (cfg_div_i),
    .uart_rx     (uart_rx),
    .uart_rts    (uart_rts),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .rx_count_o  (rx_count_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_seen = 0;
  int ovr_seen  = 0;

  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (frame_err_o === 1'b1) ferr_seen++;
    if (overrun_o === 1'b1)   ovr_seen++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Serial line driver: one bit every div+1 cycles, then idle high.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int div, input int hold_low);
    uart_rx = 1'b0;
    repeat (div + 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (div + 1) @(negedge clk);
    end
    uart_rx = stop;
    repeat (div + 1) @(negedge clk);
    if (!stop) repeat (hold_low) @(negedge clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Sends one frame and checks the exact cycle it lands. The stop-bit
  // decision is registered L posedges after the start edge is driven:
  // 2 synchroniser stages + 1 edge-detect cycle, half a bit to mid-start,
  // then nine full bit periods (8 data + stop).
  task automatic frame_check(input logic [7:0] b, input logic stop, input int div, input logic pop_at_push);
    int L;
    int m;
    L = 4 + div / 2 + 9 * (div + 1);
    m = exp_q.size();
    cfg_div_i = 16'(div);
    fork
      drive_frame(b, stop, div, 40);
      begin
        repeat (L - 1) @(negedge clk);
        check("count_before_push", rx_count_o, m);
        check("valid_before_push", rx_valid_o, (m != 0) ? 1 : 0);
        if (pop_at_push) rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
        if (pop_at_push && exp_q.size() > 0) void'(exp_q.pop_front());
        if (stop) begin
          check("overrun_pulse", overrun_o, (exp_q.size() == DEPTH) ? 1 : 0);
          if (exp_q.size() < DEPTH) exp_q.push_back(b);
        end else begin
          check("overrun_pulse", overrun_o, 0);
        end
        check("frame_err_pulse", frame_err_o, stop ? 0 : 1);
        check("count_after_push", rx_count_o, exp_q.size());
        check("rts_at_push", uart_rts, (m >= DEPTH - 2) ? 1 : 0);
        if (exp_q.size() > 0) check("head_data", rx_data_o, exp_q[0]);
        @(negedge clk);
        check("frame_err_one_cycle", frame_err_o, 0);
        check("overrun_one_cycle", overrun_o, 0);
        check("rts_after_push", uart_rts, (exp_q.size() >= DEPTH - 2) ? 1 : 0);
      end
    join
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      check("drain_valid", rx_valid_o, 1);
      check("drain_data", rx_data_o, exp_q[0]);
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
      void'(exp_q.pop_front());
    end
    check("drain_empty_valid", rx_valid_o, 0);
    check("drain_empty_count", rx_count_o, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic [7:0] rb;
    int rdiv;
    logic rstop;

    rst_n      = 1'b0;
    cfg_en_i   = 1'b1;
    cfg_div_i  = 16'd15;
    uart_rx    = 1'b1;
    rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_valid", rx_valid_o, 0);
    check("reset_data", rx_data_o, 0);
    check("reset_count", rx_count_o, 0);
    check("reset_frame_err", frame_err_o, 0);
    check("reset_overrun", overrun_o, 0);
    check("reset_rts", uart_rts, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rts_low_after_reset", uart_rts, 0);

    // Basic frame, no consumer.
    frame_check(8'hA5, 1'b1, 15, 1'b0);
    check("no_err_pulses", ferr_seen + ovr_seen, 0);

    // Short low glitch on idle line is rejected at the start-bit sample.
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (24) @(negedge clk);
    check("glitch_count", rx_count_o, exp_q.size());
    check("glitch_no_ferr", ferr_seen, 0);
    frame_check(8'h3C, 1'b1, 15, 1'b0);
    drain();

    // Bad stop bit followed by a held-low line: exactly one error.
    f0 = ferr_seen;
    frame_check(8'h3C, 1'b0, 15, 1'b0);
    check("break_single_ferr", ferr_seen - f0, 1);
    check("break_count", rx_count_o, 0);
    frame_check(8'h5A, 1'b1, 15, 1'b0);
    drain();

    // Fill to full and beyond; RTS and overrun timing checked per frame.
    for (int i = 0; i <= DEPTH; i++) frame_check(8'(i), 1'b1, 15, 1'b0);
    check("overrun_total", ovr_seen, 1);
    drain();

    // Full FIFO with a pop in the push cycle: no overrun, new byte at tail.
    for (int i = 0; i < DEPTH; i++) frame_check(8'($urandom), 1'b1, 7, 1'b0);
    frame_check(8'h77, 1'b1, 15, 1'b1);
    check("full_pop_tail", exp_q[DEPTH-1], 8'h77);
    check("overrun_total_after_pop", ovr_seen, 1);
    drain();

    // Disable forces RTS high.
    cfg_en_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rts_disabled", uart_rts, 1);
    cfg_en_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rts_reenabled", uart_rts, 0);

    // Randomized frames: random byte, divisor and occasional bad stop bit.
    for (int i = 0; i < 14; i++) begin
      rb    = 8'($urandom);
      rdiv  = $urandom_range(3, 24);
      rstop = ($urandom_range(0, 5) != 0);
      frame_check(rb, rstop, rdiv, (exp_q.size() == DEPTH) && ($urandom_range(0, 1) == 1));
      if (exp_q.size() >= 5 && $urandom_range(0, 2) == 0) drain();
    end
    drain();

    // Asynchronous reset in the middle of data bit 3 with data buffered.
    frame_check(8'h11, 1'b1, 15, 1'b0);
    frame_check(8'h22, 1'b1, 15, 1'b0);
    cfg_div_i = 16'd15;
    fork
      drive_frame(8'hE7, 1'b1, 15, 0);
      begin
        repeat (16 * 4 + 8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", rx_valid_o, 0);
        check("async_reset_count", rx_count_o, 0);
        check("async_reset_data", rx_data_o, 0);
        check("async_reset_rts", uart_rts, 1);
      end
    join
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    check("rts_high_at_release", uart_rts, 1);
    @(negedge clk);
    check("rts_low_after_release", uart_rts, 0);
    frame_check(8'h81, 1'b1, 15, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
